// File: rtl/secuenciador_tabla_verdad.sv
// ---------------------------------------------------------------------------
// secuenciador_tabla_verdad
//
// Self-test sequencer for the two-input gate unit. After a start request it
// drives the four {A,B} combinations, captures the seven gate outputs for
// each, then streams one 4-bit truth table per gate over a valid/ready
// handshake. Every gate whose table differs from the golden value is flagged.
//
// Parameters:
//   ESPERA           cycles each combination is held before sampling (1..15)
//
// Ports:
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   inicio           start request, accepted only in IDLE or FIN
//   entradaA/B       operands driven to the gate unit (0 outside APLICAR)
//   resultados[6:0]  gate outputs: AND,NAND,OR,NOR,NOT-A,XOR,XNOR (bit 0..6)
//   tabla_valid      table on tabla_dato/tabla_compuerta is valid
//   tabla_ready      consumer accepts the presented table
//   tabla_dato[3:0]  truth table, bit k = output for {A,B} = k
//   tabla_compuerta  gate index 0..6 of the presented table
//   ocupado          sequence in progress (APLICAR or ENTREGAR)
//   hecho            one-cycle completion pulse
//   error            OR of error_mask
//   error_mask[6:0]  sticky per-gate mismatch flags, cleared on accepted start
// ---------------------------------------------------------------------------
module secuenciador_tabla_verdad #(
    parameter int ESPERA = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inicio,
    output logic       entradaA,
    output logic       entradaB,
    input  logic [6:0] resultados,
    output logic       tabla_valid,
    input  logic       tabla_ready,
    output logic [3:0] tabla_dato,
    output logic [2:0] tabla_compuerta,
    output logic       ocupado,
    output logic       hecho,
    output logic       error,
    output logic [6:0] error_mask
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] APLICAR  = 2'd1;
    localparam logic [1:0] ENTREGAR = 2'd2;
    localparam logic [1:0] FIN      = 2'd3;

    // Golden tables, gate g in bits [4g+3:4g]: XNOR,XOR,NOT-A,NOR,OR,NAND,AND.
    localparam logic [27:0] GOLDEN = {4'h9, 4'h6, 4'h3, 4'h1, 4'hE, 4'h7, 4'h8};

    localparam logic [3:0] ULTIMA_ESPERA = 4'(ESPERA - 1);

    logic [1:0]      estado;
    logic [1:0]      k;
    logic [3:0]      espera_cnt;
    logic [2:0]      g;
    logic [6:0][3:0] tablas;
    logic [6:0][3:0] tablas_next;
    logic [6:0]      mask_next;

    // Tables with the current combination's outputs merged in; on the last
    // combination these are the completed tables compared against golden.
    // NOTE: always_comb uses blocking '=' with a default assignment first so
    // every path assigns every bit and no latch is inferred.
    always_comb begin
        tablas_next = tablas;
        mask_next   = '0;
        for (int i = 0; i < 7; i++) begin
            tablas_next[i][k] = resultados[i];
            mask_next[i]      = (tablas_next[i] != GOLDEN[i*4 +: 4]);
        end
    end

    // NOTE: sequential state uses non-blocking '<='; the capture registers are
    // a handful of flops, so they are reset along with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado     <= IDLE;
            k          <= '0;
            espera_cnt <= '0;
            g          <= '0;
            tablas     <= '0;
            error_mask <= '0;
        end else begin
            case (estado)
                IDLE, FIN: begin
                    // FIN accepts a start exactly like IDLE does.
                    if (inicio) begin
                        estado     <= APLICAR;
                        k          <= '0;
                        espera_cnt <= '0;
                        g          <= '0;
                        tablas     <= '0;
                        error_mask <= '0;
                    end else begin
                        estado <= IDLE;
                    end
                end
                APLICAR: begin
                    if (espera_cnt == ULTIMA_ESPERA) begin
                        espera_cnt <= '0;
                        tablas     <= tablas_next;
                        k          <= k + 2'd1;
                        if (k == 2'd3) begin
                            // Mask is updated here so it is valid together
                            // with the first tabla_valid.
                            estado     <= ENTREGAR;
                            g          <= '0;
                            error_mask <= mask_next;
                        end
                    end else begin
                        espera_cnt <= espera_cnt + 4'd1;
                    end
                end
                ENTREGAR: begin
                    if (tabla_ready) begin
                        if (g == 3'd6) begin
                            estado <= FIN;
                            g      <= '0;
                        end else begin
                            g <= g + 3'd1;
                        end
                    end
                end
                default: estado <= IDLE;
            endcase
        end
    end

    // All outputs decode directly from registers, so an asynchronous reset
    // drives them to 0 in the same cycle.
    assign entradaA        = (estado == APLICAR) & k[1];
    assign entradaB        = (estado == APLICAR) & k[0];
    assign tabla_valid     = (estado == ENTREGAR);
    assign tabla_dato      = tabla_valid ? tablas[g] : 4'd0;
    assign tabla_compuerta = tabla_valid ? g : 3'd0;
    assign ocupado         = (estado == APLICAR) | (estado == ENTREGAR);
    assign hecho           = (estado == FIN);
    assign error           = |error_mask;

endmodule

// File: tb/tb_secuenciador_tabla_verdad.sv
// ---------------------------------------------------------------------------
// Bench for secuenciador_tabla_verdad: a gate-unit model with stuck-at-0
// fault injection, a scoreboard of expected tables, table-driven runs plus
// hand-written backpressure, ignored-start, restart, reset and ESPERA=1 runs.
// ---------------------------------------------------------------------------
module tb_secuenciador_tabla_verdad;

    typedef struct {
        logic [2:0] g;
        logic [3:0] d;
    } sb_t;

    typedef struct {
        string      name;
        logic [6:0] faults;
        logic [6:0] exp_mask;
    } vec_t;

    localparam logic [3:0] GOLD [7] = '{4'h8, 4'h7, 4'hE, 4'h1, 4'h3, 4'h6, 4'h9};

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   xfer_count = 0;
    int   last_xfer_cyc = 0;
    sb_t  sb [$];

    // Instance with default ESPERA=2
    logic       inicio, entradaA, entradaB, tabla_valid, tabla_ready;
    logic       ocupado, hecho, error;
    logic [6:0] resultados, error_mask, fault_zero;
    logic [3:0] tabla_dato;
    logic [2:0] tabla_compuerta;

    // Instance with ESPERA=1
    logic       inicio1, entA1, entB1, valid1, ready1, ocup1, hecho1, err1;
    logic [6:0] res1, mask1;
    logic [3:0] dato1;
    logic [2:0] comp1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] gate_model(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~a, ~(a | b), a | b, ~(a & b), a & b};
    endfunction

    assign resultados = gate_model(entradaA, entradaB) & ~fault_zero;
    assign res1       = gate_model(entA1, entB1);

    wire [19:0] outs  = {entradaA, entradaB, tabla_valid, tabla_dato, tabla_compuerta,
                         ocupado, hecho, error, error_mask};
    wire [19:0] outs1 = {entA1, entB1, valid1, dato1, comp1, ocup1, hecho1, err1, mask1};

    secuenciador_tabla_verdad dut (
        .clk(clk), .rst_n(rst_n), .inicio(inicio),
        .entradaA(entradaA), .entradaB(entradaB), .resultados(resultados),
        .tabla_valid(tabla_valid), .tabla_ready(tabla_ready),
        .tabla_dato(tabla_dato), .tabla_compuerta(tabla_compuerta),
        .ocupado(ocupado), .hecho(hecho), .error(error), .error_mask(error_mask)
    );

    secuenciador_tabla_verdad #(.ESPERA(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .inicio(inicio1),
        .entradaA(entA1), .entradaB(entB1), .resultados(res1),
        .tabla_valid(valid1), .tabla_ready(ready1),
        .tabla_dato(dato1), .tabla_compuerta(comp1),
        .ocupado(ocup1), .hecho(hecho1), .error(err1), .error_mask(mask1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to 1 time unit after the next rising edge: sample and drive point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {entradaA, entradaB, tabla_valid, ocupado, hecho} in cycle c of
    // a run with tabla_ready held high; start accepted at edge 0.
    function automatic logic [4:0] exp_status(input int c, input int e);
        int kk;
        if (c >= 1 && c <= 4 * e) begin
            kk = (c - 1) / e;
            return {kk[1], kk[0], 1'b0, 1'b1, 1'b0};
        end
        if (c >= 4 * e + 1 && c <= 4 * e + 7) return 5'b00110;
        if (c == 4 * e + 8) return 5'b00001;
        return 5'b00000;
    endfunction

    task automatic push_expected(input logic [6:0] faults);
        for (int i = 0; i < 7; i++) begin
            sb_t e;
            e.g = 3'(i);
            e.d = faults[i] ? 4'h0 : GOLD[i];
            sb.push_back(e);
        end
    endtask

    // Scoreboard: every handshake transfer pops and compares one table.
    always @(negedge clk) begin
        if (rst_n && tabla_valid && tabla_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("tabla", 32'({tabla_compuerta, tabla_dato}), 32'({e.g, e.d}));
            end
            xfer_count++;
            last_xfer_cyc = cyc;
        end
    end

    // Full run with ready=1 on the ESPERA=2 instance, checked every cycle.
    // noisy pulses inicio in cycles 3 and 11; restart raises inicio in the
    // hecho cycle so the next run_seq starts from FIN.
    task automatic run_seq(input string name, input logic [6:0] faults,
                           input logic [6:0] exp_mask, input bit noisy, input bit restart);
        logic [4:0] st;
        push_expected(faults);
        fault_zero  = faults;
        tabla_ready = 1'b1;
        inicio      = 1'b1;
        step();
        for (int c = 1; c <= 16; c++) begin
            st = exp_status(c, 2);
            check({name, "_status"},
                  32'({entradaA, entradaB, tabla_valid, ocupado, hecho}), 32'(st));
            if (!st[2]) check({name, "_idle_data"}, 32'({tabla_compuerta, tabla_dato}), 32'd0);
            if (c == 1) check({name, "_mask_clear"}, 32'(error_mask), 32'd0);
            if (c == 9) check({name, "_mask"}, 32'({error, error_mask}), 32'({|exp_mask, exp_mask}));
            if (c == 16) check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
            inicio = (noisy && (c == 3 || c == 11)) || (restart && c == 16);
            if (c < 16) step();
        end
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{"clean",  7'h00, 7'h00};
        vecs[1] = '{"xor_0",  7'h20, 7'h20};
        vecs[2] = '{"and_0",  7'h01, 7'h01};
        vecs[3] = '{"nor_0",  7'h08, 7'h08};
        vecs[4] = '{"all_0",  7'h7F, 7'h7F};

        rst_n = 1'b0; inicio = 1'b0; tabla_ready = 1'b0; fault_zero = '0;
        inicio1 = 1'b0; ready1 = 1'b1;
        step(); step();
        check("reset_outs", 32'(outs), 32'd0);
        check("reset_outs1", 32'(outs1), 32'd0);
        rst_n = 1'b1;
        step();

        // Table-driven runs
        foreach (vecs[i]) begin
            run_seq(vecs[i].name, vecs[i].faults, vecs[i].exp_mask, 1'b0, 1'b0);
            step();
        end

        // Ignored inicio in cycles 3 and 11, then restart from the hecho cycle
        run_seq("ignored", 7'h20, 7'h20, 1'b1, 1'b1);
        run_seq("restart", 7'h00, 7'h00, 1'b0, 1'b0);
        inicio = 1'b0;
        step();
        check("idle_after", 32'({ocupado, hecho}), 32'd0);

        // Backpressure: ready low in cycles 9..12, then toggling
        begin
            bit seen = 1'b0;
            int hecho_cyc = 0;
            push_expected(7'h00);
            fault_zero  = '0;
            tabla_ready = 1'b0;
            xfer_count  = 0;
            inicio      = 1'b1;
            step();
            inicio = 1'b0;
            for (int c = 1; c <= 40; c++) begin
                if (c >= 9 && c <= 12)
                    check("bp_hold", 32'({tabla_valid, tabla_compuerta, tabla_dato}),
                          32'({1'b1, 3'd0, 4'h8}));
                if (hecho) begin
                    seen = 1'b1;
                    hecho_cyc = cyc;
                    break;
                end
                tabla_ready = (c <= 12) ? 1'b0 : c[0];
                step();
            end
            check("bp_hecho_seen", 32'(seen), 32'd1);
            check("bp_xfers", 32'(xfer_count), 32'd7);
            check("bp_hecho_lat", 32'(hecho_cyc - last_xfer_cyc), 32'd1);
            tabla_ready = 1'b1;
            step();
        end

        // Asynchronous reset in cycle 5 of a run
        push_expected(7'h00);
        inicio = 1'b1;
        step();
        inicio = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'(outs), 32'd0);
        sb.delete();
        step();
        check("rst_hold", 32'(outs), 32'd0);
        rst_n = 1'b1;
        step(); step();
        check("rst_no_hecho", 32'(outs), 32'd0);
        run_seq("post_rst", 7'h00, 7'h00, 1'b0, 1'b0);
        step();

        // ESPERA=1 instance
        inicio1 = 1'b1;
        step();
        inicio1 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            check("e1_status", 32'({entA1, entB1, valid1, ocup1, hecho1}), 32'(exp_status(c, 1)));
            if (c >= 5 && c <= 11)
                check("e1_tabla", 32'({comp1, dato1}), 32'({3'(c - 5), GOLD[c - 5]}));
            if (c == 5) check("e1_mask", 32'({err1, mask1}), 32'd0);
            step();
        end
        check("e1_idle", 32'(outs1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/secuenciador_tabla_verdad.md
# secuenciador_tabla_verdad

Self-test sequencer for the two-input logic-gate unit (AND, NAND, OR, NOR, NOT-A, XOR, XNOR). On a start pulse it drives all four input combinations onto the gate unit and captures the seven gate outputs for each combination. It then streams one 4-bit truth table per gate through a valid/ready handshake and flags every gate whose table differs from the golden value. It sits between the gate unit and the board-level display/UART logic.

## Interface
- ESPERA, default 2: cycles each input combination is held before its outputs are sampled (legal range 1..15).
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- inicio  in  1  start request, sampled high on a rising edge; accepted only when idle.
- entradaA  out  1  operand A to the gate unit.
- entradaB  out  1  operand B to the gate unit.
- resultados  in  7  gate-unit outputs; bit 0 AND, 1 NAND, 2 OR, 3 NOR, 4 NOT-A, 5 XOR, 6 XNOR. Combinational from entradaA/entradaB.
- tabla_valid  out  1  truth table on tabla_dato/tabla_compuerta is valid.
- tabla_ready  in  1  consumer accepts the table.
- tabla_dato  out  4  truth table; bit k holds the gate output for {A,B} = k.
- tabla_compuerta  out  3  gate index 0..6 of the presented table.
- ocupado  out  1  a sequence is in progress.
- hecho  out  1  one-cycle pulse when the sequence completes.
- error  out  1  OR of error_mask.
- error_mask  out  7  per-gate mismatch flags; sticky until the next accepted inicio.

## Operation
- FSM states: IDLE, APLICAR, ENTREGAR, FIN.
- IDLE:
  - inicio=1 moves to APLICAR with combination counter k=0 and wait counter 0.
  - The same accept clears error_mask and the capture registers.
- APLICAR:
  - Drives {entradaA,entradaB} = k for ESPERA cycles.
  - On the last of those cycles, resultados[g] is written into bit k of table register g, for all g.
  - k then increments. After k=3 is captured, moves to ENTREGAR with gate index g=0.
- Golden tables (bit3..bit0):
  - AND 1000, NAND 0111, OR 1110, NOR 0001.
  - NOT-A 0011, XOR 0110, XNOR 1001.
- error_mask[g] is set when the completed table for gate g differs from its golden table. The update happens on the transition into ENTREGAR, so error_mask is valid in the same cycle tabla_valid first rises.
- ENTREGAR:
  - Presents table g with tabla_valid=1.
  - On tabla_valid & tabla_ready, g increments. After g=6 is accepted, moves to FIN.
- FIN: lasts one cycle with hecho=1 and ocupado=0, then returns to IDLE. inicio sampled in FIN is accepted as if in IDLE.
- While not in IDLE/FIN:
  - ocupado=1.
  - inicio is ignored; it is not queued.
- entradaA/entradaB return to 0 outside APLICAR.

## Timing
- Reset values: every output is 0, state is IDLE, all counters and registers are 0.
- rst_n low at any time, including mid-sequence, forces all outputs to reset values immediately (asynchronous). No hecho is issued for the aborted run.
- inicio accepted at edge 0:
  - Combination k is driven in cycles 1+k·ESPERA .. (k+1)·ESPERA.
  - tabla_valid first rises in cycle 4·ESPERA+1.
- Handshake rules:
  - While tabla_valid=1 and tabla_ready=0, tabla_dato and tabla_compuerta hold stable.
  - tabla_valid never drops before the transfer.
  - Back-to-back transfers are allowed, so 7 consecutive cycles is the minimum for all tables.
  - tabla_ready high while tabla_valid=0 has no effect.
- With tabla_ready tied to 1, hecho is high in cycle 4·ESPERA+8.
- tabla_dato and tabla_compuerta are 0 whenever tabla_valid=0.

## Test plan
- Correct gate model, ESPERA=2, ready=1, inicio at edge 0 -> tables 8,7,E,1,3,6,9 for gates 0..6 in cycles 9..15; hecho in cycle 16; error=0, error_mask=0.
- resultados[5] (XOR) forced to 0 -> gate 5 reports tabla_dato=0; error_mask=7'b0100000 and error=1 from cycle 9; all other tables are golden.
- Backpressure: ready=0 for cycles 9..12, then toggling -> gate 0 table held stable through cycle 12; exactly 7 transfers, in order 0..6; hecho one cycle after the 7th transfer.
- inicio pulsed in cycles 3 and 11 -> both ignored. inicio in the hecho cycle -> a new run starts and error_mask clears.
- rst_n low in cycle 5 -> all outputs 0 in the same cycle. After release, inicio runs a full clean sequence.
- ESPERA=1, ready=1 -> combinations driven in cycles 1..4, tables in cycles 5..11, hecho in cycle 12.
